storage_wb_ctrl: RTL and testbench
==================================

// Module: storage_wb_ctrl
// PURPOSE
//  Bus-side initiator for the storage SRAM macro wrapper. Accepts Wishbone-classic
//  slave cycles from the management core and drives the wrapper's R/W port:
//  active-low enable/write strobes, byte mask, address and write data. Captures
//  returned read data and acks. Also runs a request/valid reader on the RO port.
// PARAMETERS
//  RAM_BLOCKS     2             number of SRAM blocks behind the wrapper (1..4)
//  BASE_ADR       32'h0100_0000 Wishbone base address of the storage window
//  ADR_MASK       32'hFFFF_F000 bits compared against BASE_ADR for window match
// PORTS
//  mgmt_clk       in   1               single clock, all logic on rising edge
//  mgmt_rst       in   1               asynchronous, active-high reset
//  wb_cyc_i       in   1               Wishbone cycle
//  wb_stb_i       in   1               Wishbone strobe
//  wb_we_i        in   1               1 = write
//  wb_sel_i       in   4               byte selects
//  wb_adr_i       in   32              byte address
//  wb_dat_i       in   32              write data
//  wb_ack_o       out  1               single-cycle acknowledge
//  wb_dat_o       out  32              read data, valid while wb_ack_o=1
//  mgmt_ena       out  RAM_BLOCKS      per-block chip select, active low
//  mgmt_wen       out  RAM_BLOCKS      per-block write enable, active low
//  mgmt_wen_mask  out  RAM_BLOCKS*4    per-block byte mask, active high
//  mgmt_addr      out  8               word address, shared
//  mgmt_wdata     out  32              write data, shared
//  mgmt_rdata     in   RAM_BLOCKS*32   per-block read data
//  ro_req         in   1               RO read request, sampled when ro_ready=1
//  ro_addr        in   8               RO word address
//  ro_ready       out  1               RO reader idle, can accept ro_req
//  ro_valid       out  1               one-cycle pulse, ro_data valid
//  ro_data        out  32              RO read data, held until next ro_valid
//  mgmt_ena_ro    out  1               RO chip select to block 0, active low
//  mgmt_addr_ro   out  8               RO address
//  mgmt_rdata_ro  in   32              RO read data
// BEHAVIOUR
//  Reset: mgmt_ena/mgmt_wen all 1s, mask/addr/wdata 0, wb_ack_o 0, wb_dat_o 0,
//   mgmt_ena_ro 1, mgmt_addr_ro 0, ro_ready 1, ro_valid 0, ro_data 0.
//   Reset mid-transaction returns all outputs to these values at once; no ack issued.
//  Decode: hit = cyc & stb & ((wb_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
//   word addr = wb_adr_i[9:2]; block = wb_adr_i[11:10]. Non-hit: ignored, no ack.
//  All SRAM-side outputs are registered. SRAM samples at the edge ending the
//   strobe cycle; dout is valid in the following cycle.
//  FSM states IDLE, WRITE, RD_ISSUE, RD_WAIT, ACK.
//   IDLE: on hit & we -> WRITE; on hit & !we -> RD_ISSUE.
//   WRITE (cycle N+1): mgmt_ena[blk]=0, mgmt_wen[blk]=0, mask[blk]=wb_sel_i -> ACK.
//   RD_ISSUE (N+1): mgmt_ena[blk]=0, mgmt_wen all 1 -> RD_WAIT.
//   RD_WAIT (N+2): wb_dat_o <= mgmt_rdata[blk*32 +: 32] at cycle end -> ACK.
//   ACK: wb_ack_o=1 for exactly one cycle -> IDLE. Next request accepted no earlier
//    than the cycle after ack. Latency: write ack at N+2, read ack at N+3.
//  Boundaries: block >= RAM_BLOCKS: no strobe issued; write acked, read returns 0.
//   Write with wb_sel_i=0: acked, no strobe. wb_cyc_i dropped in any non-IDLE
//   state: abort to IDLE, no ack; SRAM strobe already issued completes.
//   Strobes deasserted (1s) in every state except WRITE/RD_ISSUE.
//  RO reader: ro_req & ro_ready at N -> mgmt_ena_ro=0, addr registered, ro_ready=0
//   in N+1; ro_data captured end of N+2; ro_valid=1 in N+3; ro_ready=1 in N+3,
//   so a new request may be accepted in N+3. Fully independent of the R/W FSM;
//   same-address RO read during R/W write returns SRAM-defined data.
// STRUCTURE
//  storage_pkg: FSM state enum, WORD_LSB=2, BLK_LSB=10, SRAM_RD_LATENCY=1.
//  Sub-module storage_ro_reader: RO port request/valid engine.
// TESTING
//  Write 0xDEADBEEF sel=4'hF to block0 word 5 -> ena[0]/wen[0] low 1 cycle, ack N+2.
//  Read back block0 word 5 -> ack at N+3 with wb_dat_o=0xDEADBEEF.
//  Write sel=4'b0010 data 0x0000AA00 to block1 word 0 -> mask[7:4]=4'b0010; read 0xAA00 byte.
//  Read block 3 (RAM_BLOCKS=2) -> no strobe, ack with 0; cyc dropped in RD_WAIT -> no ack.
//  ro_req addr 5 while R/W write to block1 runs -> ro_valid at N+3, ro_data=0xDEADBEEF.
//  Assert mgmt_rst in RD_WAIT -> all outputs at reset values same cycle, no ack.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared types and address-layout constants for the storage SRAM wrapper initiator.
package storage_pkg;
  localparam int WORD_LSB        = 2;
  localparam int BLK_LSB         = 10;
  localparam int SRAM_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_ACK
  } wb_state_t;

  typedef enum logic [1:0] {
    RO_IDLE,
    RO_ISSUE,
    RO_WAIT
  } ro_state_t;
endpackage

// File: rtl/storage_ro_reader.sv
// Request/valid reader for the SRAM read-only port; one read in flight at a time.
module storage_ro_reader
  import storage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ro_req,
  input  logic [7:0]  ro_addr,
  output logic        ro_ready,
  output logic        ro_valid,
  output logic [31:0] ro_data,
  output logic        mgmt_ena_ro,
  output logic [7:0]  mgmt_addr_ro,
  input  logic [31:0] mgmt_rdata_ro
);
  ro_state_t   state_q, state_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        ena_q, ena_d;
  logic [7:0]  addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ena_d   = 1'b1;
    addr_d  = addr_q;
    case (state_q)
      RO_IDLE: begin
        if (ro_req) begin
          ena_d   = 1'b0;
          addr_d  = ro_addr;
          ready_d = 1'b0;
          state_d = RO_ISSUE;
        end
      end
      RO_ISSUE: state_d = RO_WAIT;
      RO_WAIT: begin
        // SRAM output is valid this cycle; ready returns with the valid pulse
        data_d  = mgmt_rdata_ro;
        valid_d = 1'b1;
        ready_d = 1'b1;
        state_d = RO_IDLE;
      end
      default: state_d = RO_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RO_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      ena_q   <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
    end
  end

  assign ro_ready     = ready_q;
  assign ro_valid     = valid_q;
  assign ro_data      = data_q;
  assign mgmt_ena_ro  = ena_q;
  assign mgmt_addr_ro = addr_q;
endmodule

// File: rtl/storage_wb_ctrl.sv
// Wishbone-classic slave driving the storage SRAM wrapper R/W port, plus the RO-port reader.
module storage_wb_ctrl
  import storage_pkg::*;
#(
  parameter int          RAM_BLOCKS = 2,
  parameter logic [31:0] BASE_ADR   = 32'h0100_0000,
  parameter logic [31:0] ADR_MASK   = 32'hFFFF_F000
) (
  input  logic                    mgmt_clk,
  input  logic                    mgmt_rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic                    wb_ack_o,
  output logic [31:0]             wb_dat_o,
  output logic [RAM_BLOCKS-1:0]   mgmt_ena,
  output logic [RAM_BLOCKS-1:0]   mgmt_wen,
  output logic [RAM_BLOCKS*4-1:0] mgmt_wen_mask,
  output logic [7:0]              mgmt_addr,
  output logic [31:0]             mgmt_wdata,
  input  logic [RAM_BLOCKS*32-1:0] mgmt_rdata,
  input  logic                    ro_req,
  input  logic [7:0]              ro_addr,
  output logic                    ro_ready,
  output logic                    ro_valid,
  output logic [31:0]             ro_data,
  output logic                    mgmt_ena_ro,
  output logic [7:0]              mgmt_addr_ro,
  input  logic [31:0]             mgmt_rdata_ro
);
  localparam logic [1:0] RD_LAST = 2'(SRAM_RD_LATENCY - 1);

  // One-hot block select; blocks not present decode to all zeros (no strobe).
  function automatic logic [RAM_BLOCKS-1:0] blk_decode(input logic [1:0] blk);
    logic [RAM_BLOCKS-1:0] oh;
    oh = '0;
    for (int i = 0; i < RAM_BLOCKS; i++) oh[i] = (blk == 2'(i));
    return oh;
  endfunction

  wb_state_t             state_q, state_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [RAM_BLOCKS-1:0] ena_q, ena_d, wen_q, wen_d;
  logic [RAM_BLOCKS*4-1:0] mask_q, mask_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            blk_q, blk_d;
  logic [1:0]            rd_cnt_q, rd_cnt_d;

  logic                  hit;
  logic [1:0]            adr_blk;
  logic [RAM_BLOCKS-1:0] adr_oh;

  assign hit     = wb_cyc_i & wb_stb_i & ((wb_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
  assign adr_blk = wb_adr_i[BLK_LSB+1:BLK_LSB];
  assign adr_oh  = blk_decode(adr_blk);

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_d    = dat_q;
    ena_d    = '1;
    wen_d    = '1;
    mask_d   = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    blk_d    = blk_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          addr_d = wb_adr_i[BLK_LSB-1:WORD_LSB];
          blk_d  = adr_blk;
          if (wb_we_i) begin
            wdata_d = wb_dat_i;
            if (wb_sel_i != 4'b0000) begin
              ena_d = ~adr_oh;
              wen_d = ~adr_oh;
              for (int i = 0; i < RAM_BLOCKS; i++)
                if (adr_oh[i]) mask_d[i*4 +: 4] = wb_sel_i;
            end
            state_d = ST_WRITE;
          end else begin
            ena_d   = ~adr_oh;
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_WRITE: begin
        ack_d   = wb_cyc_i;
        state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
      end
      ST_RD_ISSUE: begin
        rd_cnt_d = '0;
        state_d  = wb_cyc_i ? ST_RD_WAIT : ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (rd_cnt_q == RD_LAST) begin
          dat_d = '0;
          for (int i = 0; i < RAM_BLOCKS; i++)
            if (blk_q == 2'(i)) dat_d = mgmt_rdata[i*32 +: 32];
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_rst) begin
    if (mgmt_rst) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ena_q    <= '1;
      wen_q    <= '1;
      mask_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      blk_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ena_q    <= ena_d;
      wen_q    <= wen_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      blk_q    <= blk_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign mgmt_ena      = ena_q;
  assign mgmt_wen      = wen_q;
  assign mgmt_wen_mask = mask_q;
  assign mgmt_addr     = addr_q;
  assign mgmt_wdata    = wdata_q;

  storage_ro_reader u_ro_reader (
    .clk           (mgmt_clk),
    .rst           (mgmt_rst),
    .ro_req        (ro_req),
    .ro_addr       (ro_addr),
    .ro_ready      (ro_ready),
    .ro_valid      (ro_valid),
    .ro_data       (ro_data),
    .mgmt_ena_ro   (mgmt_ena_ro),
    .mgmt_addr_ro  (mgmt_addr_ro),
    .mgmt_rdata_ro (mgmt_rdata_ro)
  );
endmodule

// File: tb/tb_storage_wb_ctrl.sv
// Directed bench for storage_wb_ctrl with a behavioural two-block SRAM wrapper model.
module tb_storage_wb_ctrl;
  localparam int RB = 2;

  logic              mgmt_clk = 1'b0;
  logic              mgmt_rst;
  logic              wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_adr_i, wb_dat_i;
  logic              wb_ack_o;
  logic [31:0]       wb_dat_o;
  logic [RB-1:0]     mgmt_ena, mgmt_wen;
  logic [RB*4-1:0]   mgmt_wen_mask;
  logic [7:0]        mgmt_addr;
  logic [31:0]       mgmt_wdata;
  logic [RB*32-1:0]  mgmt_rdata;
  logic              ro_req;
  logic [7:0]        ro_addr;
  logic              ro_ready, ro_valid;
  logic [31:0]       ro_data;
  logic              mgmt_ena_ro;
  logic [7:0]        mgmt_addr_ro;
  logic [31:0]       mgmt_rdata_ro;

  always #5 mgmt_clk = ~mgmt_clk;

  storage_wb_ctrl #(
    .RAM_BLOCKS (RB),
    .BASE_ADR   (32'h0100_0000),
    .ADR_MASK   (32'hFFFF_F000)
  ) dut (
    .mgmt_clk      (mgmt_clk),
    .mgmt_rst      (mgmt_rst),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_sel_i      (wb_sel_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_o      (wb_ack_o),
    .wb_dat_o      (wb_dat_o),
    .mgmt_ena      (mgmt_ena),
    .mgmt_wen      (mgmt_wen),
    .mgmt_wen_mask (mgmt_wen_mask),
    .mgmt_addr     (mgmt_addr),
    .mgmt_wdata    (mgmt_wdata),
    .mgmt_rdata    (mgmt_rdata),
    .ro_req        (ro_req),
    .ro_addr       (ro_addr),
    .ro_ready      (ro_ready),
    .ro_valid      (ro_valid),
    .ro_data       (ro_data),
    .mgmt_ena_ro   (mgmt_ena_ro),
    .mgmt_addr_ro  (mgmt_addr_ro),
    .mgmt_rdata_ro (mgmt_rdata_ro)
  );

  // SRAM wrapper model: samples on the edge ending the strobe cycle, dout next cycle.
  logic [31:0] mem [RB][256];
  logic [31:0] rdata_blk [RB];
  logic        mem_clr;

  always @(posedge mgmt_clk) begin
    if (mem_clr) begin
      for (int b = 0; b < RB; b++) begin
        rdata_blk[b] <= '0;
        for (int w = 0; w < 256; w++) mem[b][w] <= '0;
      end
      mgmt_rdata_ro <= '0;
    end else begin
      for (int b = 0; b < RB; b++) begin
        if (!mgmt_ena[b]) begin
          if (!mgmt_wen[b])
            for (int j = 0; j < 4; j++)
              if (mgmt_wen_mask[b*4+j]) mem[b][mgmt_addr][8*j +: 8] <= mgmt_wdata[8*j +: 8];
          rdata_blk[b] <= mem[b][mgmt_addr];
        end
      end
      if (!mgmt_ena_ro) mgmt_rdata_ro <= mem[0][mgmt_addr_ro];
    end
  end

  always_comb begin
    mgmt_rdata = '0;
    for (int b = 0; b < RB; b++) mgmt_rdata[b*32 +: 32] = rdata_blk[b];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mgmt_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ena"},      64'(mgmt_ena),      64'(2'b11));
    chk({tag, " wen"},      64'(mgmt_wen),      64'(2'b11));
    chk({tag, " mask"},     64'(mgmt_wen_mask), 64'h0);
    chk({tag, " addr"},     64'(mgmt_addr),     64'h0);
    chk({tag, " wdata"},    64'(mgmt_wdata),    64'h0);
    chk({tag, " ack"},      64'(wb_ack_o),      64'h0);
    chk({tag, " dat_o"},    64'(wb_dat_o),      64'h0);
    chk({tag, " ena_ro"},   64'(mgmt_ena_ro),   64'h1);
    chk({tag, " addr_ro"},  64'(mgmt_addr_ro),  64'h0);
    chk({tag, " ro_ready"}, 64'(ro_ready),      64'h1);
    chk({tag, " ro_valid"}, 64'(ro_valid),      64'h0);
    chk({tag, " ro_data"},  64'(ro_data),       64'h0);
  endtask

  typedef struct {
    logic            we;
    logic [3:0]      sel;
    logic [31:0]     adr;
    logic [31:0]     dat;
    int              exp_ack;   // cycle of ack after request cycle N; 0 = never
    logic [31:0]     exp_rd;
    logic [RB-1:0]   exp_ena;   // AND of mgmt_ena over the transfer
    logic [RB-1:0]   exp_wen;
    logic [RB*4-1:0] exp_mask;  // OR of mask over the transfer
    int              exp_strb;  // cycles with any chip select low
  } vec_t;

  vec_t vt [12];

  // Drives one Wishbone cycle starting now (cycle N) and observes the SRAM side until ack.
  task automatic run_xfer(input vec_t v, output int ack_at, output logic [31:0] rd,
                          output logic [RB-1:0] ena_s, output logic [RB-1:0] wen_s,
                          output logic [RB*4-1:0] mask_s, output int strb, output logic [7:0] addr_s);
    ack_at = 0; rd = '0; ena_s = '1; wen_s = '1; mask_s = '0; strb = 0; addr_s = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
    wb_sel_i = v.sel; wb_adr_i = v.adr; wb_dat_i = v.dat;
    for (int k = 1; k <= 8 && ack_at == 0; k++) begin
      step();
      if (mgmt_ena != '1) begin
        strb++;
        addr_s = mgmt_addr;
      end
      ena_s  = ena_s & mgmt_ena;
      wen_s  = wen_s & mgmt_wen;
      mask_s = mask_s | mgmt_wen_mask;
      if (wb_ack_o) begin
        ack_at = k;
        rd     = wb_dat_o;
      end
    end
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  int              ack_at, strb, acks;
  logic [31:0]     rd;
  logic [RB-1:0]   ena_s, wen_s;
  logic [RB*4-1:0] mask_s;
  logic [7:0]      addr_s;
  logic [7:0]      exp_word;

  initial begin
    vt[0]  = '{1'b1, 4'hF, 32'h0100_0014, 32'hDEADBEEF, 2, 32'h0,        2'b10, 2'b10, 8'h0F, 1};
    vt[1]  = '{1'b0, 4'hF, 32'h0100_0014, 32'h0,        3, 32'hDEADBEEF, 2'b10, 2'b11, 8'h00, 1};
    vt[2]  = '{1'b1, 4'h2, 32'h0100_0400, 32'h0000AA00, 2, 32'h0,        2'b01, 2'b01, 8'h20, 1};
    vt[3]  = '{1'b0, 4'hF, 32'h0100_0400, 32'h0,        3, 32'h0000AA00, 2'b01, 2'b11, 8'h00, 1};
    vt[4]  = '{1'b0, 4'hF, 32'h0100_0C00, 32'h0,        3, 32'h0,        2'b11, 2'b11, 8'h00, 0};
    vt[5]  = '{1'b1, 4'hF, 32'h0100_0800, 32'hCAFEF00D, 2, 32'h0,        2'b11, 2'b11, 8'h00, 0};
    vt[6]  = '{1'b1, 4'h0, 32'h0100_0018, 32'h12345678, 2, 32'h0,        2'b11, 2'b11, 8'h00, 0};
    vt[7]  = '{1'b0, 4'hF, 32'h0100_0018, 32'h0,        3, 32'h0,        2'b10, 2'b11, 8'h00, 1};
    vt[8]  = '{1'b1, 4'h9, 32'h0100_0018, 32'hAABBCCDD, 2, 32'h0,        2'b10, 2'b10, 8'h09, 1};
    vt[9]  = '{1'b0, 4'hF, 32'h0100_0018, 32'h0,        3, 32'hAA0000DD, 2'b10, 2'b11, 8'h00, 1};
    vt[10] = '{1'b1, 4'hF, 32'h0200_0014, 32'h11111111, 0, 32'h0,        2'b11, 2'b11, 8'h00, 0};
    vt[11] = '{1'b0, 4'hF, 32'h0100_07FC, 32'h0,        3, 32'h0,        2'b01, 2'b11, 8'h00, 1};

    mgmt_rst = 1'b1; mem_clr = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0;
    ro_req = 1'b0; ro_addr = '0;
    repeat (3) step();
    chk_reset_vals("reset");
    mgmt_rst = 1'b0; mem_clr = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_xfer(vt[i], ack_at, rd, ena_s, wen_s, mask_s, strb, addr_s);
      chk($sformatf("v%0d ack_cycle", i), 64'(ack_at), 64'(vt[i].exp_ack));
      if (!vt[i].we && vt[i].exp_ack != 0)
        chk($sformatf("v%0d rdata", i), 64'(rd), 64'(vt[i].exp_rd));
      chk($sformatf("v%0d ena", i),   64'(ena_s),  64'(vt[i].exp_ena));
      chk($sformatf("v%0d wen", i),   64'(wen_s),  64'(vt[i].exp_wen));
      chk($sformatf("v%0d mask", i),  64'(mask_s), 64'(vt[i].exp_mask));
      chk($sformatf("v%0d strobe_cycles", i), 64'(strb), 64'(vt[i].exp_strb));
      if (vt[i].exp_strb != 0) begin
        exp_word = vt[i].adr[9:2];
        chk($sformatf("v%0d word_addr", i), 64'(addr_s), 64'(exp_word));
      end
      if (vt[i].exp_ack != 0)
        chk($sformatf("v%0d ack_one_cycle", i), 64'(wb_ack_o), 64'h0);
    end

    // Cycle dropped while waiting for read data: strobe already out, no ack afterwards.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'hF; wb_adr_i = 32'h0100_0014;
    step();
    chk("abort strobe_issued", 64'(mgmt_ena), 64'(2'b10));
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (wb_ack_o) acks++;
    end
    chk("abort no_ack", 64'(acks), 64'h0);
    run_xfer(vt[1], ack_at, rd, ena_s, wen_s, mask_s, strb, addr_s);
    chk("post_abort ack_cycle", 64'(ack_at), 64'd3);
    chk("post_abort rdata", 64'(rd), 64'hDEADBEEF);

    // RO read of block0 word 5 concurrent with an R/W write to block1, then a back-to-back RO read.
    chk("ro ready_idle", 64'(ro_ready), 64'h1);
    ro_req = 1'b1; ro_addr = 8'd5;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_sel_i = 4'hF; wb_adr_i = 32'h0100_0414; wb_dat_i = 32'h55AA55AA;
    step();
    chk("ro n1 ready",   64'(ro_ready),     64'h0);
    chk("ro n1 ena_ro",  64'(mgmt_ena_ro),  64'h0);
    chk("ro n1 addr_ro", 64'(mgmt_addr_ro), 64'h5);
    chk("ro n1 valid",   64'(ro_valid),     64'h0);
    chk("rw n1 ena",     64'(mgmt_ena),     64'(2'b01));
    ro_req = 1'b0;
    step();
    chk("ro n2 valid",  64'(ro_valid),    64'h0);
    chk("ro n2 ena_ro", 64'(mgmt_ena_ro), 64'h1);
    chk("rw n2 ack",    64'(wb_ack_o),    64'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
    chk("ro n3 valid", 64'(ro_valid), 64'h1);
    chk("ro n3 data",  64'(ro_data),  64'hDEADBEEF);
    chk("ro n3 ready", 64'(ro_ready), 64'h1);
    ro_req = 1'b1; ro_addr = 8'd6;
    step();
    chk("ro n4 valid", 64'(ro_valid), 64'h0);
    chk("ro n4 ready", 64'(ro_ready), 64'h0);
    chk("ro n4 held",  64'(ro_data),  64'hDEADBEEF);
    ro_req = 1'b0;
    step();
    chk("ro n5 valid", 64'(ro_valid), 64'h0);
    step();
    chk("ro n6 valid", 64'(ro_valid), 64'h1);
    chk("ro n6 data",  64'(ro_data),  64'hAA0000DD);
    step();
    vt[0].we = 1'b0; vt[0].adr = 32'h0100_0414;
    run_xfer(vt[0], ack_at, rd, ena_s, wen_s, mask_s, strb, addr_s);
    chk("blk1 w5 rdata", 64'(rd), 64'h55AA55AA);

    // Asynchronous reset while in RD_WAIT: outputs return to reset values without an edge.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'hF; wb_adr_i = 32'h0100_0014;
    step();
    step();
    mgmt_rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    mgmt_rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (wb_ack_o) acks++;
    end
    chk("midrst no_ack", 64'(acks), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
